// File: rtl/z80_turbo_clken.sv
// z80_turbo_clken: CPU T-state clock-enable generator with selectable turbo
// divisors, fetch-boundary mode switching and wait insertion for slow accesses.
module z80_turbo_clken #(
   parameter int unsigned BASE_DIV    = 8,
   parameter int unsigned MODES       = 4,
   parameter int unsigned TURBO_WAITS = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] turbo_req,
   input  logic       hold,
   input  logic       m1_n,
   input  logic       mreq_n,
   input  logic       iorq_n,
   input  logic       rd_n,
   input  logic       wr_n,
   input  logic       slow_access,
   output logic       clken,
   output logic       wait_n,
   output logic [1:0] turbo_act,
   output logic       mode_chg
);

   localparam int unsigned CNT_W  = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
   localparam int unsigned WCNT_W = 4;
   localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(BASE_DIV - 1);
   localparam logic [1:0]        MODE_MAX = 2'(MODES - 1);
   localparam logic [WCNT_W-1:0] WAIT_LD  = WCNT_W'(TURBO_WAITS);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAITING = 2'd1,
      S_DONE    = 2'd2
   } wait_state_t;

   logic [CNT_W-1:0]  cnt;
   logic              pend_valid;
   logic [1:0]        pend_mode;
   logic [WCNT_W-1:0] wcnt;
   wait_state_t       state;
   wait_state_t       state_d;
   logic [WCNT_W-1:0] wcnt_d;
   logic              wait_n_d;

   logic [1:0]       req_c;
   logic             tick_c;
   logic             apply_c;
   logic [1:0]       act_next_c;
   logic [CNT_W-1:0] reload_c;
   logic             access_c;
   logic             trig_c;

   // Request clamping, T-state tick, mode apply and wait trigger decode
   always_comb begin
      req_c      = (32'(turbo_req) >= MODES) ? MODE_MAX : turbo_req;
      tick_c     = !hold && (cnt == '0);
      apply_c    = tick_c && !m1_n && pend_valid;
      act_next_c = apply_c ? pend_mode : turbo_act;
      reload_c   = CNT_W'((BASE_DIV >> act_next_c) - 32'd1);
      access_c   = slow_access && (!mreq_n || !iorq_n) && (!rd_n || !wr_n);
      trig_c     = tick_c && (act_next_c != 2'd0) && access_c && (TURBO_WAITS != 0);
   end

   // Divider: reload on tick with the divisor of the mode in effect after this edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= CNT_INIT;
         clken <= 1'b0;
      end else if (tick_c) begin
         cnt   <= reload_c;
         clken <= 1'b1;
      end else begin
         if (!hold) cnt <= cnt - CNT_W'(1);
         clken <= 1'b0;
      end
   end

   // Pending request tracks the latest clamped request; applied only at M1 ticks
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         turbo_act  <= 2'd0;
         mode_chg   <= 1'b0;
         pend_valid <= 1'b0;
         pend_mode  <= 2'd0;
      end else begin
         turbo_act  <= act_next_c;
         mode_chg   <= apply_c;
         pend_valid <= (req_c != act_next_c);
         pend_mode  <= req_c;
      end
   end

   // Wait FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_d;
   end

   // Wait FSM next-state logic
   always_comb begin
      state_d = state;
      case (state)
         S_IDLE:    if (trig_c) state_d = S_WAITING;
         S_WAITING: if (tick_c && (wcnt <= WCNT_W'(1))) state_d = S_DONE;
         S_DONE:    if (mreq_n && iorq_n) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Wait FSM outputs: counter next value and WAIT_n level
   always_comb begin
      wcnt_d   = wcnt;
      wait_n_d = (state_d != S_WAITING);
      case (state)
         S_IDLE:    if (trig_c) wcnt_d = WAIT_LD;
         S_WAITING: if (tick_c) wcnt_d = wcnt - WCNT_W'(1);
         default:   wcnt_d = wcnt;
      endcase
   end

   // Wait counter and registered WAIT_n
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wcnt   <= '0;
         wait_n <= 1'b1;
      end else begin
         wcnt   <= wcnt_d;
         wait_n <= wait_n_d;
      end
   end

endmodule

// File: tb/tb_z80_turbo_clken.sv
// tb_z80_turbo_clken: directed checks of divider, mode switching and wait insertion.
module tb_z80_turbo_clken;

   logic       clk;
   logic       rst;
   logic [1:0] turbo_req;
   logic       hold, m1_n, mreq_n, iorq_n, rd_n, wr_n, slow_access;
   logic       clken, wait_n, mode_chg;
   logic [1:0] turbo_act;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic [1:0] req;
      logic [1:0] act;
      int         period;
   } mode_vec_t;

   mode_vec_t vecs [4];

   z80_turbo_clken #(.BASE_DIV(8), .MODES(4), .TURBO_WAITS(2)) dut (
      .clk(clk), .rst(rst), .turbo_req(turbo_req), .hold(hold), .m1_n(m1_n),
      .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
      .slow_access(slow_access), .clken(clken), .wait_n(wait_n),
      .turbo_act(turbo_act), .mode_chg(mode_chg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // cycles from the current sample until the next clken sample (bounded)
   task automatic period(output int n);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         n++;
         if (clken) break;
      end
   endtask

   // edge number of the first clken after reset release (called just after release)
   task automatic first_clken(output int n);
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (clken) begin
            n = i;
            break;
         end
      end
   endtask

   // wait until wait_n goes low; found=1 on success
   task automatic wait_low(output int found, output int ck);
      found = 0;
      ck = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (!wait_n) begin
            found = 1;
            ck = int'(clken);
            break;
         end
      end
   endtask

   task automatic do_mode(input logic [1:0] req, input logic [1:0] act, input int per);
      int found, n, extra;
      turbo_req = req;
      m1_n = 1'b0;
      found = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (mode_chg) begin
            found = 1;
            break;
         end
      end
      chk("mode_chg_seen", found, 1);
      chk("mode_chg_with_clken", int'(clken), 1);
      chk("turbo_act_applied", int'(turbo_act), int'(act));
      m1_n = 1'b1;
      extra = 0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         n++;
         if (mode_chg) extra++;
         if (clken) break;
      end
      chk("mode_chg_single_pulse", extra, 0);
      chk("period_after_change", n, per);
      period(n);
      chk("period_steady", n, per);
   endtask

   initial begin
      int n, found, ck, cnt_a, cnt_b;

      vecs[0] = '{req: 2'd2, act: 2'd2, period: 2};
      vecs[1] = '{req: 2'd3, act: 2'd3, period: 1};
      vecs[2] = '{req: 2'd1, act: 2'd1, period: 4};
      vecs[3] = '{req: 2'd0, act: 2'd0, period: 8};

      rst = 1'b1;
      turbo_req = 2'd0;
      hold = 1'b0; m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1;
      rd_n = 1'b1; wr_n = 1'b1; slow_access = 1'b0;

      // reset values
      step(); step();
      chk("rst_clken", int'(clken), 0);
      chk("rst_wait_n", int'(wait_n), 1);
      chk("rst_turbo_act", int'(turbo_act), 0);
      chk("rst_mode_chg", int'(mode_chg), 0);

      @(negedge clk) rst = 1'b0;
      first_clken(n);
      chk("first_clken_edge", n, 8);
      period(n);
      chk("mode0_period", n, 8);

      // pending request cancelled when request returns to the active mode
      turbo_req = 2'd1;
      for (int i = 0; i < 12; i++) step();
      turbo_req = 2'd2;
      for (int i = 0; i < 12; i++) step();
      turbo_req = 2'd0;
      step(); step();
      m1_n = 1'b0;
      cnt_a = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (mode_chg) cnt_a++;
      end
      chk("cancel_no_mode_chg", cnt_a, 0);
      chk("cancel_turbo_act", int'(turbo_act), 0);
      m1_n = 1'b1;

      // table of mode transitions
      for (int v = 0; v < 4; v++) do_mode(vecs[v].req, vecs[v].act, vecs[v].period);

      // slow access wait in mode 1
      do_mode(2'd1, 2'd1, 4);
      slow_access = 1'b1; mreq_n = 1'b0; rd_n = 1'b0;
      wait_low(found, ck);
      chk("wait_trigger", found, 1);
      chk("wait_trigger_on_clken", ck, 1);
      n = 1;
      for (int i = 0; i < 40; i++) begin
         step();
         if (wait_n) break;
         n++;
      end
      chk("wait_low_cycles", n, 8);

      cnt_a = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (!wait_n) cnt_a++;
      end
      chk("no_retrigger", cnt_a, 0);

      mreq_n = 1'b1;
      step(); step(); step();
      mreq_n = 1'b0;
      wait_low(found, ck);
      chk("retrigger_new_access", found, 1);

      // hold during WAITING
      step(); step();
      hold = 1'b1;
      cnt_a = 0; cnt_b = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (clken) cnt_a++;
         if (wait_n) cnt_b++;
      end
      chk("hold_no_clken", cnt_a, 0);
      chk("hold_wait_n_low", cnt_b, 0);
      hold = 1'b0;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (wait_n) break;
         n++;
      end
      chk("hold_resume_remaining", n, 5);

      mreq_n = 1'b1; rd_n = 1'b1;
      step(); step(); step();

      // async reset mid-wait in mode 2
      do_mode(2'd2, 2'd2, 2);
      mreq_n = 1'b0; rd_n = 1'b0;
      wait_low(found, ck);
      chk("mode2_wait_trigger", found, 1);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_wait_n", int'(wait_n), 1);
      chk("async_rst_clken", int'(clken), 0);
      chk("async_rst_turbo_act", int'(turbo_act), 0);
      mreq_n = 1'b1; rd_n = 1'b1; slow_access = 1'b0;
      step();
      @(negedge clk) rst = 1'b0;
      first_clken(n);
      chk("post_rst_first_clken", n, 8);
      period(n);
      chk("post_rst_period", n, 8);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/z80_turbo_clken.md
Name: z80_turbo_clken

Overview:
- Generates the CPU clock-enable for the T80-based core from the single system clock.
- Supports several selectable turbo speeds.
- Mode changes are applied only at opcode-fetch boundaries, so the CPU never sees a truncated T-state.
- In turbo modes, inserts a programmable number of wait T-states on accesses flagged as slow, so slow memory and I/O keep their timing.

Parameters:
- BASE_DIV, 8, system clocks per CPU T-state in mode 0. Must be a power of two and ≥ 2^(MODES-1).
- MODES, 4, number of speed modes. Mode m divisor = BASE_DIV >> m.
- TURBO_WAITS, 1, wait T-states inserted per slow access when the active mode is nonzero. Range 0..15.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- turbo_req  in  2  requested speed mode
- hold  in  1  freeze: no clken pulses while high
- m1_n  in  1  CPU M1 strobe
- mreq_n  in  1  CPU MREQ strobe
- iorq_n  in  1  CPU IORQ strobe
- rd_n  in  1  CPU RD strobe
- wr_n  in  1  CPU WR strobe
- slow_access  in  1  current access targets a slow device
- clken  out  1  one-clk CPU T-state enable pulse
- wait_n  out  1  to CPU WAIT_n
- turbo_act  out  2  speed mode currently in effect
- mode_chg  out  1  one-clk pulse when a new mode takes effect

Behaviour:
- Reset (async, rst=1), all registers immediately:
  - clken=0, wait_n=1, turbo_act=0, mode_chg=0
  - divider counter cnt=BASE_DIV-1, pending request cleared, wait FSM in IDLE
- Divider:
  - cnt is clog2(BASE_DIV) bits and is registered.
  - hold=1: cnt frozen, clken=0.
  - hold=0 and cnt=0: clken=1 for that clk, and cnt reloads with div(turbo_act)-1.
  - Otherwise cnt decrements and clken=0.
  - Divisor 1 (cnt always 0): clken stays high every clk while hold=0.
  - First clken after reset release occurs on the BASE_DIV-th clock edge.
- Mode request:
  - turbo_req ≥ MODES is clamped to MODES-1.
  - A clamped value different from turbo_act is latched as pending. Latest value wins; a request equal to turbo_act cancels the pending one.
- Mode apply:
  - Happens on a clken pulse where m1_n=0 and a request is pending.
  - turbo_act updates on that edge, and the reload on the same edge already uses the new divisor.
  - mode_chg pulses 1 clk, coincident with the turbo_act update.
- Wait FSM, states IDLE -> WAITING -> DONE:
  - IDLE -> WAITING: on a clken pulse with turbo_act≠0, slow_access=1, (mreq_n=0 or iorq_n=0), (rd_n=0 or wr_n=0), and TURBO_WAITS≠0. wait_n goes 0 on the next clk and the wait counter loads TURBO_WAITS.
  - WAITING: the wait counter decrements on each clken pulse. When it reaches 0, wait_n returns to 1 and the FSM moves to DONE.
  - hold freezes the wait counter, because it counts only clken pulses.
  - DONE -> IDLE: when mreq_n=1 and iorq_n=1. There is no retrigger within the same access.
  - TURBO_WAITS=0 or turbo_act=0: wait_n stays 1 and the FSM stays in IDLE.
- Simultaneous events: a mode change and a wait trigger on the same clken use the new turbo_act value for the wait decision.
- Reset mid-wait releases wait_n to 1 immediately (async).
- Mode change while WAITING: the FSM finishes its current count unaffected.

Test Plan:
- Reset release, turbo_req=0, hold=0 -> first clken on edge 8, then one clken every 8 clks; wait_n=1; turbo_act=0.
- turbo_req=2 at clk 20, m1_n=0 at the next clken -> turbo_act=2 and mode_chg pulse at that clken; subsequent clken period is 2 clks. Repeat with turbo_req=3 -> clken continuously high.
- turbo_req toggles 1 -> 2 -> 0 with m1_n=1 throughout, then m1_n=0 -> turbo_act stays 0 and mode_chg never pulses (pending cancelled).
- turbo_act=1, TURBO_WAITS=2, slow_access=1, mreq_n=0, rd_n=0 at a clken -> wait_n low for exactly 2 clken pulses (8 clks), then high; strobe held low -> no retrigger; mreq_n high then low again -> new wait.
- hold=1 for 10 clks during WAITING -> no clken, wait_n stays 0, cnt frozen; resumes with the remaining count after hold=0.
- rst asserted mid-wait in mode 2 -> same clk: wait_n=1, clken=0, turbo_act=0; after release, period is 8 clks.
